alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised, handshaked execute stage for the 5-bit opcode ISA (ADD..DON).
//  Accepts one op at a time, drives a registered result with a valid/ready handshake and keeps the CMP flags.
//  Resolves branches BE/BL/BG/BA and runs SLL/SRL on a multi-cycle 1-bit/cycle shifter.
//  Sits between decode/regfile read and writeback/memory.
// PARAMETERS
//  W    8           datapath width in bits (>=4)
//  OPW  5           opcode width
//  SHW  $clog2(W)   shift-amount bits taken from b
// PORTS
//  Clk       in   1    clock, rising edge
//  Reset_n   in   1    asynchronous reset, active-low
//  in_valid  in   1    op/a/b valid
//  in_ready  out  1    unit can accept (combinational from state)
//  op        in   OPW  opcode: ADD=0,SUB,XOR,AND,SLL,SRL,CMP,BE,BL,BG,BA,MOV,LD,ST,DON=14
//  a         in   W    operand A
//  b         in   W    operand B / shift amount
//  out_valid out  1    result registers valid
//  out_ready in   1    downstream accepts result
//  result    out  W    result value
//  out_op    out  OPW  echo of the accepted opcode
//  wr_en     out  1    result targets a register (ADD,SUB,XOR,AND,SLL,SRL,MOV)
//  br_taken  out  1    branch resolved taken
//  flag_c    out  1    carry (ADD) / borrow (SUB)
//  flag_eq   out  1    last CMP: a==b
//  flag_lt   out  1    last CMP: a<b (unsigned)
//  flag_gt   out  1    last CMP: a>b (unsigned)
//  illegal   out  1    accepted opcode >14
//  halted    out  1    DON executed
// BEHAVIOUR
//  Reset: async on Reset_n low; all registered outputs 0, FSM->IDLE; aborts any in-flight shift. No transfer while Reset_n low.
//  FSM: IDLE, SHIFT, HALT.
//   - in_ready = (state==IDLE) && (!out_valid || out_ready).
//   - Transfer when in_valid && in_ready.
//  IDLE, non-shift op: result/out_op/wr_en/br_taken/illegal registered on the accept edge; out_valid=1 next cycle (latency 1).
//  Shifts, amt = b[SHW-1:0]:
//   - b[W-1:SHW]!=0 -> result 0, latency 1.
//   - amt==0 -> result a, latency 1.
//   - else load a, IDLE->SHIFT; shift 1 bit/cycle for amt cycles (SLL zero-fill, SRL logical), then out_valid.
//   - Latency amt+1 cycles; in_ready=0 throughout SHIFT.
//  ADD/SUB: mod 2^W; flag_c = carry-out (ADD) or borrow, a<b (SUB). Other ops leave flag_c.
//  Logic/move: XOR/AND bitwise; MOV result=b.
//  LD/ST: result = a+b (effective address), wr_en=0, flags unchanged.
//  CMP: updates eq/lt/gt on accept; result=0, wr_en=0. The next accepted op sees the new flags.
//  Branches: BE taken=flag_eq, BL=flag_lt, BG=flag_gt, BA=1; result=0, wr_en=0.
//  Branch flags before any CMP: eq/lt/gt=0 -> only BA taken.
//  DON: out_valid with halted=1, state->HALT; in_ready=0 until Reset_n low.
//  Illegal op: result 0, illegal=1, no flag change.
//  Backpressure: while out_valid && !out_ready, all outputs hold stable; no new accept.
//   - out_valid clears on out_ready unless a new op's result lands that same edge (back-to-back, 1 op/cycle).
// TESTING (W=8)
//  1. ADD a=F0 b=20 -> 1 cycle later out_valid, result=10, flag_c=1, wr_en=1.
//  2. SLL a=01 b=03 -> in_ready=0 for 3 cycles, result=08 at cycle 4; SLL b=09 -> result=00 latency 1.
//  3. CMP 05,09 then BL -> br_taken=1; then BE -> 0, BG -> 0, BA -> 1; flags eq/lt/gt=0/1/0.
//  4. SUB 03,05 with out_ready=0 for 5 cycles -> result=FE, flag_c=1 held stable, in_ready=0; released on out_ready=1.
//  5. DON -> halted=1, in_ready stays 0 for 10+ cycles with in_valid=1; Reset_n pulse -> IDLE, halted=0.
//  6. SRL a=80 b=07, Reset_n low at cycle 3 -> all outputs 0 immediately; after release in_ready=1, op=1F gives illegal=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute stage with registered result, CMP flags,
// branch resolution and a 1-bit/cycle shifter for SLL/SRL.
module alu_exec_unit #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 5,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic [OPW-1:0] out_op,
  output logic           wr_en,
  output logic           br_taken,
  output logic           flag_c,
  output logic           flag_eq,
  output logic           flag_lt,
  output logic           flag_gt,
  output logic           illegal,
  output logic           halted
);
  localparam logic [OPW-1:0] OP_ADD = OPW'(0),  OP_SUB = OPW'(1),  OP_XOR = OPW'(2),
                             OP_AND = OPW'(3),  OP_SLL = OPW'(4),  OP_SRL = OPW'(5),
                             OP_CMP = OPW'(6),  OP_BE  = OPW'(7),  OP_BL  = OPW'(8),
                             OP_BG  = OPW'(9),  OP_BA  = OPW'(10), OP_MOV = OPW'(11),
                             OP_LD  = OPW'(12), OP_ST  = OPW'(13), OP_DON = OPW'(14);

  typedef enum logic [1:0] {IDLE, SHIFT, HALT} state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   res_q, res_d;
  logic [OPW-1:0] op_q, op_d;
  logic           vld_q, vld_d, wr_q, wr_d, br_q, br_d, c_q, c_d;
  logic           eq_q, eq_d, lt_q, lt_d, gt_q, gt_d, ill_q, ill_d, halt_q, halt_d;
  logic [W:0]     sum, dif;
  logic           accept, hi_nz;

  assign in_ready = (state_q == IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign dif      = {1'b0, a} - {1'b0, b};
  assign hi_nz    = |b[W-1:SHW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    res_d   = res_q;
    op_d    = op_q;
    wr_d    = wr_q;
    br_d    = br_q;
    c_d     = c_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    ill_d   = ill_q;
    halt_d  = halt_q;
    if (state_q == SHIFT) begin
      res_d = (op_q == OP_SRL) ? res_q >> 1 : res_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        vld_d   = 1'b1;
        state_d = IDLE;
      end
    end else if (accept) begin
      op_d  = op;
      vld_d = 1'b1;
      wr_d  = 1'b0;
      br_d  = 1'b0;
      ill_d = 1'b0;
      res_d = '0;
      case (op)
        OP_ADD: begin res_d = sum[W-1:0]; c_d = sum[W]; wr_d = 1'b1; end
        OP_SUB: begin res_d = dif[W-1:0]; c_d = dif[W]; wr_d = 1'b1; end
        OP_XOR, OP_AND, OP_MOV: begin
          wr_d  = 1'b1;
          res_d = (op == OP_XOR) ? a ^ b : (op == OP_AND) ? a & b : b;
        end
        OP_SLL, OP_SRL: begin
          wr_d  = 1'b1;
          res_d = hi_nz ? '0 : a;
          // Only a real nonzero in-range amount needs the multi-cycle path.
          if (!hi_nz && b[SHW-1:0] != '0) begin
            vld_d   = 1'b0;
            cnt_d   = b[SHW-1:0];
            state_d = SHIFT;
          end
        end
        OP_CMP: begin eq_d = (a == b); lt_d = (a < b); gt_d = (a > b); end
        OP_BE:  br_d = eq_q;
        OP_BL:  br_d = lt_q;
        OP_BG:  br_d = gt_q;
        OP_BA:  br_d = 1'b1;
        OP_LD, OP_ST: res_d = sum[W-1:0];
        OP_DON: begin halt_d = 1'b1; state_d = HALT; end
        default: ill_d = 1'b1;
      endcase
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      op_q    <= '0;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      c_q     <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      ill_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      c_q     <= c_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      ill_q   <= ill_d;
      halt_q  <= halt_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign out_op    = op_q;
  assign wr_en     = wr_q;
  assign br_taken  = br_q;
  assign flag_c    = c_q;
  assign flag_eq   = eq_q;
  assign flag_lt   = lt_q;
  assign flag_gt   = gt_q;
  assign illegal   = ill_q;
  assign halted    = halt_q;
endmodule
